// File: rtl/lookup3_pkg.sv
// -----------------------------------------------------------------------------
// lookup3_pkg
// Shared definitions for the lookup3 final() avalanche pipeline:
//   - ROT_F1..ROT_F7 : rotation amounts of the seven final() lines
//   - WSEL_A/B/C     : selects which state word a stage rewrites
//   - lk3_state_t    : the (a, b, c) state triple
//   - rot32()        : 32-bit rotate left
//   - stage_rot()/stage_word() : per-stage rotation and target word
// -----------------------------------------------------------------------------
package lookup3_pkg;

  localparam int ROT_F1 = 14;
  localparam int ROT_F2 = 11;
  localparam int ROT_F3 = 25;
  localparam int ROT_F4 = 16;
  localparam int ROT_F5 = 4;
  localparam int ROT_F6 = 14;
  localparam int ROT_F7 = 24;

  localparam int WSEL_A = 0;
  localparam int WSEL_B = 1;
  localparam int WSEL_C = 2;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } lk3_state_t;

  // k is always 1..31 here, so neither shift degenerates.
  function automatic logic [31:0] rot32(input logic [31:0] x, input int unsigned k);
    return (x << k) | (x >> (32 - k));
  endfunction

  function automatic int stage_rot(input int s);
    case (s)
      0:       return ROT_F1;
      1:       return ROT_F2;
      2:       return ROT_F3;
      3:       return ROT_F4;
      4:       return ROT_F5;
      5:       return ROT_F6;
      default: return ROT_F7;
    endcase
  endfunction

  // final() rewrites c, a, b, c, a, b, c in that order.
  function automatic int stage_word(input int s);
    case (s % 3)
      0:       return WSEL_C;
      1:       return WSEL_A;
      default: return WSEL_B;
    endcase
  endfunction

endpackage

// File: rtl/lookup3_final_stage.sv
// -----------------------------------------------------------------------------
// lookup3_final_stage
// One registered line of the lookup3 final() avalanche. The selected word X is
// replaced by (X ^ Y) - rot(Y, ROT_K), where Y is the word that precedes X in
// the c <- b, a <- c, b <- a chain. The other two words pass through.
//
// Parameters:
//   WORD_SEL : WSEL_A / WSEL_B / WSEL_C, the word rewritten by this stage
//   ROT_K    : rotation amount
//   TAG_W    : tag width
//   RST_DATA : also clear data/tag on reset (used for the output stage)
// Ports:
//   CLK, RST : clock, synchronous active-high reset
//   i_adv    : stage advances this cycle (loads from upstream)
//   i_vld, i_st, i_tag : upstream valid, state, tag
//   o_vld, o_st, o_tag : registered valid, state, tag of this stage
// -----------------------------------------------------------------------------
module lookup3_final_stage
  import lookup3_pkg::*;
#(
  parameter int WORD_SEL = WSEL_C,
  parameter int ROT_K    = 14,
  parameter int TAG_W    = 8,
  parameter bit RST_DATA = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_adv,
  input  logic             i_vld,
  input  lk3_state_t       i_st,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_vld,
  output lk3_state_t       o_st,
  output logic [TAG_W-1:0] o_tag
);

  lk3_state_t       w_nxt;
  lk3_state_t       r_st;
  logic [TAG_W-1:0] r_tag;
  logic             r_vld;

  always_comb begin
    w_nxt = i_st;
    case (WORD_SEL)
      WSEL_A:  w_nxt.a = (i_st.a ^ i_st.c) - rot32(i_st.c, ROT_K);
      WSEL_B:  w_nxt.b = (i_st.b ^ i_st.a) - rot32(i_st.a, ROT_K);
      default: w_nxt.c = (i_st.c ^ i_st.b) - rot32(i_st.b, ROT_K);
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vld <= 1'b0;
    end else if (i_adv) begin
      r_vld <= i_vld;
    end
  end

  // Data only moves with a valid word, so bubbles never overwrite a held
  // result and never carry unknown values forward.
  always_ff @(posedge CLK) begin
    if (RST_DATA && RST) begin
      r_st  <= '0;
      r_tag <= '0;
    end else if (i_adv && i_vld) begin
      r_st  <= w_nxt;
      r_tag <= i_tag;
    end
  end

  assign o_vld = r_vld;
  assign o_st  = r_st;
  assign o_tag = r_tag;

endmodule

// File: rtl/lookup3_final.sv
// -----------------------------------------------------------------------------
// lookup3_final
// Applies the seven lines of lookup3 final() to the (a, b, c) triple left by
// the mix rounds, one line per registered stage, and returns the final c as
// the hash together with a bucket index and the request tag.
//
// Build option:
//   LOOKUP3_FINAL_BUBBLE_EN : when defined, each stage advances independently
//     (empty stages keep filling under an output stall); otherwise a single
//     global stall freezes the whole pipeline while the output is not taken.
//
// Parameters: TAG_W (tag width), IDX_W (bucket index width, 1..32)
// Ports:
//   CLK, RST                  : clock, synchronous active-high reset
//   in_valid/in_ready         : input handshake
//   in_a, in_b, in_c, in_tag  : mix state triple and request tag
//   out_valid/out_ready       : output handshake
//   out_hash                  : final c
//   out_index                 : out_hash[IDX_W-1:0]
//   out_tag                   : tag travelling with the result
// Latency 7 cycles, throughput one triple per cycle.
// -----------------------------------------------------------------------------
module lookup3_final
  import lookup3_pkg::*;
#(
  parameter int TAG_W = 8,
  parameter int IDX_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [31:0]      in_c,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_hash,
  output logic [IDX_W-1:0] out_index,
  output logic [TAG_W-1:0] out_tag
);

  // Index 0 is the pipeline input, index g+1 the output of stage g.
  lk3_state_t       w_st  [0:7];
  logic [TAG_W-1:0] w_tag [0:7];
  logic [7:0]       w_vld;
  logic [6:0]       w_adv;
  logic             w_unused_ab;

  assign w_st[0]  = '{a: in_a, b: in_b, c: in_c};
  assign w_tag[0] = in_tag;
  assign w_vld[0] = in_valid;

  // Advance chain, resolved from the output back to the input. The output
  // stage may move whenever it is empty or its result is being taken; the
  // global-stall form is the same term broadcast to every stage.
  always_comb begin
    w_adv    = '0;
    w_adv[6] = ~w_vld[7] | out_ready;
    for (int i = 5; i >= 0; i--) begin
`ifdef LOOKUP3_FINAL_BUBBLE_EN
      w_adv[i] = ~w_vld[i+1] | w_adv[i+1];
`else
      w_adv[i] = w_adv[6];
`endif
    end
  end

  assign in_ready = w_adv[0];

  for (genvar g = 0; g < 7; g++) begin : g_stage
    lookup3_final_stage #(
      .WORD_SEL (stage_word(g)),
      .ROT_K    (stage_rot(g)),
      .TAG_W    (TAG_W),
      .RST_DATA (g == 6)
    ) u_stage (
      .CLK   (CLK),
      .RST   (RST),
      .i_adv (w_adv[g]),
      .i_vld (w_vld[g]),
      .i_st  (w_st[g]),
      .i_tag (w_tag[g]),
      .o_vld (w_vld[g+1]),
      .o_st  (w_st[g+1]),
      .o_tag (w_tag[g+1])
    );
  end

  assign out_valid = w_vld[7];
  assign out_hash  = w_st[7].c;
  assign out_index = w_st[7].c[IDX_W-1:0];
  assign out_tag   = w_tag[7];

  // Only c is consumed after the last line.
  assign w_unused_ab = ^{w_st[7].a, w_st[7].b};

endmodule

// File: tb/tb_lookup3_final.sv
module tb_lookup3_final;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0, in_b = '0, in_c = '0;
  logic [7:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_hash;
  logic [15:0] out_index;
  logic [7:0]  out_tag;

  logic        in_ready2, out_valid2;
  logic [31:0] out_hash2, out_index2;
  logic [0:0]  out_tag2;

  always #5 CLK = ~CLK;

  lookup3_final #(.TAG_W(8), .IDX_W(16)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_hash(out_hash),
    .out_index(out_index), .out_tag(out_tag)
  );

  // Narrow-tag, full-index instance fed with the same stimulus.
  lookup3_final #(.TAG_W(1), .IDX_W(32)) dut2 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_tag(in_tag[0:0]),
    .out_valid(out_valid2), .out_ready(out_ready), .out_hash(out_hash2),
    .out_index(out_index2), .out_tag(out_tag2)
  );

  typedef struct {
    logic [31:0] h;
    logic [7:0]  t;
    int          acc_cyc;
    bit          lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   n_push = 0, n_pop = 0;
  bit   lat_chk = 1'b0;
  bit   done = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int k);
    return (x << k) | (x >> (32 - k));
  endfunction

  // Straight transcription of lookup3 final().
  function automatic logic [31:0] model(input logic [31:0] a0, input logic [31:0] b0,
                                        input logic [31:0] c0);
    logic [31:0] a, b, c;
    a = a0; b = b0; c = c0;
    c ^= b; c -= rotl(b, 14);
    a ^= c; a -= rotl(c, 11);
    b ^= a; b -= rotl(a, 25);
    c ^= b; c -= rotl(b, 16);
    a ^= c; a -= rotl(c, 4);
    b ^= a; b -= rotl(a, 14);
    c ^= b; c -= rotl(b, 24);
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sync();
    @(posedge CLK); #1;
  endtask

  // Called in the posedge+1 phase; returns in the same phase after acceptance.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input logic [7:0] tag, input logic [31:0] exp_h);
    int w;
    bit acc;
    w = 0; acc = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_c = c; in_tag = tag;
    while (!acc) begin
      @(negedge CLK);
      if (in_ready) begin
        acc = 1'b1;
        q.push_back('{h: exp_h, t: tag, acc_cyc: cyc, lat: lat_chk});
        n_push++;
      end
      sync();
      if (!acc) begin
        w++;
        if (w > 300) begin
          checks++; errors++;
          $display("FAIL send_timeout: got in_ready 0 for %0d cycles required 1", w);
          break;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  // Single-cycle attempt; the triple is withdrawn if not accepted.
  task automatic try_send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic [7:0] tag, output bit acc);
    in_valid = 1'b1; in_a = a; in_b = b; in_c = c; in_tag = tag;
    @(negedge CLK);
    acc = in_ready;
    if (acc) begin
      q.push_back('{h: model(a, b, c), t: tag, acc_cyc: cyc, lat: 1'b0});
      n_push++;
    end
    sync();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 400) begin
      @(posedge CLK);
      w++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d results outstanding required 0", q.size());
    end
    repeat (3) @(posedge CLK);
    #1;
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST && out_valid === 1'b1 && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got hash %h tag %h required no output", out_hash, out_tag);
        end else begin
          e = q.pop_front();
          n_pop++;
          chk("hash", out_hash, e.h);
          chk("index", {16'h0, out_index}, {16'h0, e.h[15:0]});
          chk("tag", {24'h0, out_tag}, {24'h0, e.t});
          chk("w2_valid", {31'h0, out_valid2}, 32'd1);
          chk("w2_hash", out_hash2, e.h);
          chk("w2_index", out_index2, e.h);
          chk("w2_tag", {31'h0, out_tag2}, {31'h0, e.t[0]});
          if (e.lat) chk("latency", cyc - e.acc_cyc, 32'd7);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb, rc;
    bit          acc;
    int          n_acc;

    // Reset state
    RST = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_out_hash", out_hash, 32'd0);
    chk("rst_out_index", {16'h0, out_index}, 32'd0);
    chk("rst_out_tag", {24'h0, out_tag}, 32'd0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
    sync();

    // Zero triple: final() of all zeros is zero
    lat_chk = 1'b1;
    send(32'h0, 32'h0, 32'h0, 8'h5A, 32'h0000_0000);
    wait_drain();

    // Back-to-back random stream
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rc = $urandom;
      send(ra, rb, rc, i[7:0], model(ra, rb, rc));
    end
    wait_drain();

    // All-DEADBEEF triple
    send(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 8'hC3,
         model(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF));
    wait_drain();

    // Output stall for 20 cycles in a full stream
    lat_chk = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          ra = $urandom; rb = $urandom; rc = 32'h1000 + i;
          send(ra, rb, rc, 8'h80 + i[7:0], model(ra, rb, rc));
        end
      end
      begin
        repeat (15) sync();
        out_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(negedge CLK);
          chk("stall_out_valid", {31'h0, out_valid}, 32'd1);
          chk("stall_in_ready", {31'h0, in_ready}, 32'd0);
          chk("stall_hash", out_hash, q[0].h);
          chk("stall_tag", {24'h0, out_tag}, {24'h0, q[0].t});
        end
        sync();
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Sparse arrivals into a stalled output: buffering depth
    out_ready = 1'b0;
    n_acc = 0;
    for (int k = 0; k < 9; k++) begin
      try_send(32'h11 * k, 32'h2222 + k, 32'h3 << k, 8'h40 + k[7:0], acc);
      if (acc) n_acc++;
      repeat (2) sync();
    end
`ifdef LOOKUP3_FINAL_BUBBLE_EN
    chk("fill_count", n_acc, 32'd7);
`else
    chk("fill_count", n_acc, 32'd3);
`endif
    @(negedge CLK);
    chk("fill_in_ready", {31'h0, in_ready}, 32'd0);
    sync();
    out_ready = 1'b1;
    wait_drain();

    // Reset with four triples in flight
    for (int i = 0; i < 4; i++) begin
      ra = 32'hA0 + i;
      send(ra, ~ra, ra ^ 32'h5555_AAAA, 8'hE0 + i[7:0], model(ra, ~ra, ra ^ 32'h5555_AAAA));
    end
    RST = 1'b1;
    n_push = n_push - q.size();
    q.delete();
    sync();
    RST = 1'b0;
    @(negedge CLK);
    chk("rst2_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst2_out_hash", out_hash, 32'd0);
    chk("rst2_out_tag", {24'h0, out_tag}, 32'd0);
    chk("rst2_in_ready", {31'h0, in_ready}, 32'd1);
    sync();
    repeat (15) sync();
    lat_chk = 1'b1;
    send(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_F0F0, 8'h77,
         model(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_F0F0));
    wait_drain();

    // Toggling in_valid with random out_ready
    lat_chk = 1'b0;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          ra = $urandom; rb = $urandom; rc = $urandom;
          send(ra, rb, rc, i[7:0], model(ra, rb, rc));
          sync();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          sync();
          out_ready = 1'($urandom_range(0, 1));
          @(negedge CLK);
          chk("no_x", {31'h0, $isunknown({out_valid, in_ready, out_hash, out_index, out_tag})}, 32'd0);
        end
      end
    join
    sync();
    out_ready = 1'b1;
    wait_drain();
    chk("count", n_pop, n_push);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
